instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Top-level fetch/decode/dispatch controller for the microcontroller. It owns the program counter and instruction register, presents the current instruction to the per-opcode executor FSMs, and waits for the selected executor's done. It then retires the instruction and advances the PC. Between instructions it drives a NOP word so every executor returns to its idle state.

## Interface
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W
- OP_VALID, 16'h807F, bit k=1 means opcode k has an executor (opcodes 0..6 and F by default)
- TIMEOUT, 15, maximum EXEC cycles without done before faulting (1..255)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  level; continuous execution while high
- step  in  1  single-cycle pulse; executes exactly one instruction from IDLE
- instr_in  in  16  program memory read data for address pc (asynchronous read)
- unit_done  in  16  bit k = done from the executor for opcode k
- pc  out  PC_W  current program counter
- ir_out  out  16  instruction word broadcast to executors
- ir_load  out  1  high in FETCH (IR capture strobe)
- busy  out  1  high in FETCH, DECODE, EXEC, RETIRE
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- fault_code  out  2  0 none, 1 illegal opcode, 2 executor timeout
- retired_cnt  out  16  count of retired instructions, saturates at 16'hFFFF

## Operation
- States: IDLE, FETCH, DECODE, EXEC, RETIRE, HALT, FAULT. opcode = ir[15:12].
- IDLE: if run or step, go to FETCH. Record step_mode = step & ~run. Otherwise stay.
- FETCH: ir <= instr_in; ir_load=1; go to DECODE.
- DECODE:
  - opcode F: go to HALT.
  - opcode 0 (NOP): go to RETIRE.
  - OP_VALID[opcode]=0: go to FAULT, fault_code <= 1.
  - Otherwise go to EXEC and clear tcnt.
- EXEC: ir_out = ir. tcnt increments each cycle.
  - unit_done[opcode]=1: go to RETIRE. Done bits of other opcodes are ignored.
  - Else if tcnt == TIMEOUT: go to FAULT, fault_code <= 2.
  - If done and timeout occur in the same cycle, done wins.
- RETIRE: pc <= pc+1 (wraps), retired_cnt <= sat(retired_cnt+1).
  - Go to FETCH if run=1 and step_mode=0.
  - Otherwise go to IDLE.
- HALT and FAULT are terminal until rst. pc holds the address of the offending instruction and is not incremented. run and step are ignored.
- ir_out = 16'h0000 in every state except EXEC. This forces executors out of their instruction and back to idle.
- Dropping run mid-instruction does not abort: the current instruction completes and retires, then the block goes to IDLE.
- step while run=1 has no additional effect.
- Executor PC-increment outputs are unused; this block is the sole PC owner.

## Timing
- Reset values: state IDLE, pc 0, ir 0, ir_out 0, ir_load 0, busy 0, halted 0, fault 0, fault_code 0, retired_cnt 0, tcnt 0.
- All outputs are registered state or decoded from registered state only; no input-to-output combinational path.
- instr_in must be valid for address pc during the FETCH cycle.
- Instruction latency is FETCH(1) + DECODE(1) + EXEC(d+1) + RETIRE(1) cycles, where d is the number of edges from EXEC entry until done is sampled high.
- A 4-state executor (done in its 4th state) gives d=3, so 7 cycles per instruction. A NOP takes 3 cycles.
- EXEC lasts at most TIMEOUT+1 cycles.
- pc updates on the edge leaving RETIRE, which is also the edge entering the next FETCH.
- rst asserted in any state, including mid-EXEC, returns everything to reset values immediately. ir_out dropping to 0 releases the executors.

## Test plan
- Reset/idle: rst pulse with run=0 for 10 cycles -> all outputs at reset values, busy=0, pc=0.
- MOV dispatch: memory[0]=16'h6085, executor stub raises unit_done[6] 3 cycles after it first sees opcode 6 -> ir_out=16'h6085 for exactly 4 cycles, ir_out=0 in the RETIRE cycle, pc=1 after 7 cycles, retired_cnt=1.
- NOP stream plus wrap: run=1, all memory 16'h0000, PC_W=8 -> pc increments every 3 cycles; 256 instructions after reset pc=0 again and retired_cnt=256.
- Illegal opcode: memory[0]=16'h9000 with default OP_VALID -> FAULT after 2 cycles, fault=1, fault_code=1, pc=0, run toggling ignored.
- Timeout versus done: opcode 1 with no done -> fault_code=2 after exactly 16 EXEC cycles. Repeat with done in tcnt=15 -> retires normally, fault=0.
- Step and halt: run=0, one-cycle step with memory {0:16'h1000, 1:16'hF000} and done after 1 cycle -> one instruction retires and the block returns to IDLE with pc=1. A second step -> halted=1, pc=1, remaining there until rst.

Source files
------------

// File: rtl/instr_sequencer.sv
// Fetch/decode/dispatch controller: owns pc and ir, hands the current
// instruction to the opcode executors and retires it once they report done.
module instr_sequencer #(
    parameter int          PC_W     = 8,
    parameter logic [15:0] OP_VALID = 16'h807F,
    parameter int          TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            step,
    input  logic [15:0]     instr_in,
    input  logic [15:0]     unit_done,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir_out,
    output logic            ir_load,
    output logic            busy,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [15:0]     retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_RETIRE,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] ir;
    logic [7:0]  tcnt;
    logic        step_mode;
    logic [3:0]  opcode;
    logic        done_sel;
    logic        tmo;

    assign opcode   = ir[15:12];
    assign done_sel = unit_done[opcode];
    assign tmo      = (tcnt == 8'(TIMEOUT));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (run || step)
                    state_nx = S_FETCH;
            end
            S_FETCH: state_nx = S_DECODE;
            S_DECODE: begin
                if (opcode == 4'hF)
                    state_nx = S_HALT;
                else if (opcode == 4'h0)
                    state_nx = S_RETIRE;
                else if (!OP_VALID[opcode])
                    state_nx = S_FAULT;
                else
                    state_nx = S_EXEC;
            end
            // done takes priority over a timeout in the same cycle
            S_EXEC: begin
                if (done_sel)
                    state_nx = S_RETIRE;
                else if (tmo)
                    state_nx = S_FAULT;
            end
            S_RETIRE: begin
                if (run && !step_mode)
                    state_nx = S_FETCH;
                else
                    state_nx = S_IDLE;
            end
            S_HALT:  state_nx = S_HALT;
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            tcnt        <= '0;
            step_mode   <= 1'b0;
            fault_code  <= 2'd0;
            retired_cnt <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (run || step)
                        step_mode <= step & ~run;
                end
                S_FETCH: ir <= instr_in;
                S_DECODE: begin
                    tcnt <= '0;
                    if (state_nx == S_FAULT)
                        fault_code <= 2'd1;
                end
                S_EXEC: begin
                    tcnt <= tcnt + 8'd1;
                    if (state_nx == S_FAULT)
                        fault_code <= 2'd2;
                end
                S_RETIRE: begin
                    pc <= pc + 1'b1;
                    if (retired_cnt != 16'hFFFF)
                        retired_cnt <= retired_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // ir_out is zero outside EXEC so every executor drops back to idle
    assign ir_out  = (state == S_EXEC) ? ir : 16'h0000;
    assign ir_load = (state == S_FETCH);
    assign busy    = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC) || (state == S_RETIRE);
    assign halted  = (state == S_HALT);
    assign fault   = (state == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: executor stubs with per-address done delay and a
// per-instruction latency model driven from a random program.
module tb_instr_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic [15:0] instr_in;
    logic [15:0] unit_done;
    logic [7:0]  pc;
    logic [15:0] ir_out;
    logic        ir_load;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_code;
    logic [15:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    logic [7:0]  dly [256];
    logic [7:0]  ecnt;
    logic        noise_en;
    logic [15:0] noise;

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .instr_in    (instr_in),
        .unit_done   (unit_done),
        .pc          (pc),
        .ir_out      (ir_out),
        .ir_load     (ir_load),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault),
        .fault_code  (fault_code),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_in = mem[pc];

    // executor stub: counts cycles while it sees a nonzero instruction
    always @(posedge clk) begin
        if (ir_out == 16'h0000)
            ecnt <= 8'd0;
        else
            ecnt <= ecnt + 8'd1;
    end

    always_comb begin
        logic [15:0] oh;
        oh = 16'h1 << ir_out[15:12];
        unit_done = noise_en ? (noise & ~oh) : 16'h0000;
        if (ir_out != 16'h0000 && ecnt == dly[pc])
            unit_done = unit_done | oh;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (noise_en)
            noise = 16'($urandom);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000;
            dly[i] = 8'hFF;
        end
    endtask

    task automatic do_reset;
        run  = 1'b0;
        step = 1'b0;
        rst  = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [38:0] got;
        clear_mem();
        run  = 1'b0;
        step = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        got = {pc, ir_out, ir_load, busy, halted, fault, fault_code};
        total++;
        if (got !== 39'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", got);
        end
        total++;
        if (retired_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_retired got=%0d want=0", retired_cnt);
        end
    endtask

    task automatic test_mov;
        int n;
        clear_mem();
        mem[0] = 16'h6085;
        dly[0] = 8'd3;
        do_reset();
        run = 1'b1;
        n   = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (ir_out == 16'h6085)
                n++;
            if (c == 1) begin
                total++;
                if (ir_load !== 1'b1 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL mov_fetch ir_load=%b busy=%b want 1 1", ir_load, busy);
                end
            end
            if (c == 7) begin
                total++;
                if (ir_out !== 16'h0000 || busy !== 1'b1 || pc !== 8'd0) begin
                    bad++;
                    $display("FAIL mov_retire ir_out=%h busy=%b pc=%0d want 0000 1 0",
                             ir_out, busy, pc);
                end
                run = 1'b0;
            end
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL mov_exec_len got=%0d want=4", n);
        end
        tick();
        total++;
        if (pc !== 8'd1 || retired_cnt !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mov_after pc=%0d ret=%0d busy=%b want 1 1 0",
                     pc, retired_cnt, busy);
        end
    endtask

    task automatic test_nop_wrap;
        clear_mem();
        do_reset();
        run = 1'b1;
        tick();
        for (int k = 1; k <= 256; k++) begin
            repeat (3) tick();
            total++;
            if (pc !== 8'(k) || retired_cnt !== 16'(k)) begin
                bad++;
                $display("FAIL nop_wrap k=%0d pc=%0d ret=%0d want %0d %0d",
                         k, pc, retired_cnt, k % 256, k);
            end
        end
        run = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_illegal;
        clear_mem();
        mem[0] = 16'h9000;
        do_reset();
        run = 1'b1;
        repeat (2) tick();
        total++;
        if (fault !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL illegal_early fault=%b busy=%b want 0 1", fault, busy);
        end
        tick();
        total++;
        if (fault !== 1'b1 || fault_code !== 2'd1 || pc !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL illegal_fault fault=%b code=%0d pc=%0d busy=%b want 1 1 0 0",
                     fault, fault_code, pc, busy);
        end
        for (int i = 0; i < 10; i++) begin
            run  = 1'($urandom);
            step = 1'($urandom);
            tick();
            total++;
            if (fault !== 1'b1 || fault_code !== 2'd1 || pc !== 8'd0 ||
                ir_out !== 16'h0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL illegal_sticky fault=%b code=%0d pc=%0d ir_out=%h",
                         fault, fault_code, pc, ir_out);
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        bit done;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            mem[0] = 16'h1000;
            dly[0] = (pass == 0) ? 8'hFF : 8'd15;
            do_reset();
            run = 1'b1;
            tick();
            run  = 1'b0;
            n    = 0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                tick();
                if (ir_out == 16'h1000)
                    n++;
                if (!busy)
                    done = 1'b1;
            end
            total++;
            if (!done) begin
                bad++;
                $display("FAIL timeout_bound pass=%0d busy stuck", pass);
            end
            total++;
            if (n != 16) begin
                bad++;
                $display("FAIL timeout_exec_len pass=%0d got=%0d want=16", pass, n);
            end
            total++;
            if (pass == 0) begin
                if (fault !== 1'b1 || fault_code !== 2'd2 || pc !== 8'd0 ||
                    retired_cnt !== 16'd0) begin
                    bad++;
                    $display("FAIL timeout_fault fault=%b code=%0d pc=%0d ret=%0d want 1 2 0 0",
                             fault, fault_code, pc, retired_cnt);
                end
            end else begin
                if (fault !== 1'b0 || fault_code !== 2'd0 || pc !== 8'd1 ||
                    retired_cnt !== 16'd1) begin
                    bad++;
                    $display("FAIL timeout_done_wins fault=%b code=%0d pc=%0d ret=%0d want 0 0 1 1",
                             fault, fault_code, pc, retired_cnt);
                end
            end
        end
    endtask

    task automatic test_step_halt;
        bit done;
        clear_mem();
        mem[0] = 16'h1000;
        mem[1] = 16'hF000;
        dly[0] = 8'd1;
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (!busy)
                done = 1'b1;
        end
        repeat (3) tick();
        total++;
        if (!done || busy !== 1'b0 || pc !== 8'd1 || retired_cnt !== 16'd1 ||
            halted !== 1'b0) begin
            bad++;
            $display("FAIL step_one busy=%b pc=%0d ret=%0d halted=%b want 0 1 1 0",
                     busy, pc, retired_cnt, halted);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (2) tick();
        total++;
        if (halted !== 1'b1 || pc !== 8'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL step_halt halted=%b pc=%0d busy=%b want 1 1 0", halted, pc, busy);
        end
        for (int i = 0; i < 10; i++) begin
            run  = 1'($urandom);
            step = 1'($urandom);
            tick();
            total++;
            if (halted !== 1'b1 || pc !== 8'd1 || retired_cnt !== 16'd1) begin
                bad++;
                $display("FAIL halt_sticky halted=%b pc=%0d ret=%0d", halted, pc, retired_cnt);
            end
        end
        run  = 1'b0;
        step = 1'b0;
    endtask

    task automatic test_reset_mid_exec;
        clear_mem();
        mem[1] = 16'h6085;
        do_reset();
        run = 1'b1;
        repeat (6) tick();
        total++;
        if (ir_out !== 16'h6085 || pc !== 8'd1 || retired_cnt !== 16'd1) begin
            bad++;
            $display("FAIL midexec_pre ir_out=%h pc=%0d ret=%0d want 6085 1 1",
                     ir_out, pc, retired_cnt);
        end
        rst = 1'b1;
        #2;
        total++;
        if (ir_out !== 16'h0000 || pc !== 8'd0 || retired_cnt !== 16'd0 ||
            busy !== 1'b0 || ir_load !== 1'b0) begin
            bad++;
            $display("FAIL midexec_rst ir_out=%h pc=%0d ret=%0d busy=%b",
                     ir_out, pc, retired_cnt, busy);
        end
        run = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        localparam int N = 40;
        int lat [N];
        int t;
        int last;
        int prev;
        bit stop;
        clear_mem();
        for (int i = 0; i < N; i++) begin
            logic [3:0] op;
            op     = 4'($urandom_range(0, 6));
            mem[i] = {op, 12'($urandom)};
            dly[i] = 8'($urandom_range(0, 15));
            lat[i] = (op == 4'd0) ? 3 : int'(dly[i]) + 4;
        end
        mem[N]   = 16'hF000;
        noise_en = 1'b1;
        do_reset();
        run  = 1'b1;
        t    = 0;
        last = 1;
        prev = 0;
        stop = 1'b0;
        for (int c = 0; c < 2000 && !stop; c++) begin
            tick();
            t++;
            if (ir_out != 16'h0000) begin
                total++;
                if (ir_out !== mem[pc]) begin
                    bad++;
                    $display("FAIL b2b_ir_out pc=%0d got=%h want=%h", pc, ir_out, mem[pc]);
                end
            end
            if (int'(retired_cnt) != prev) begin
                total++;
                if (int'(retired_cnt) != prev + 1 || t - last != lat[prev] ||
                    int'(pc) != prev + 1) begin
                    bad++;
                    $display("FAIL b2b_retire idx=%0d ret=%0d pc=%0d cycles=%0d want %0d",
                             prev, retired_cnt, pc, t - last, lat[prev]);
                end
                last = t;
                prev = int'(retired_cnt);
            end
            if (halted || fault)
                stop = 1'b1;
        end
        total++;
        if (halted !== 1'b1 || t != last + 2 || retired_cnt !== 16'(N) || pc !== 8'(N)) begin
            bad++;
            $display("FAIL b2b_end halted=%b t=%0d want %0d ret=%0d pc=%0d want %0d",
                     halted, t, last + 2, retired_cnt, pc, N);
        end
        noise_en = 1'b0;
        noise    = 16'h0000;
        run      = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        run      = 1'b0;
        step     = 1'b0;
        noise_en = 1'b0;
        noise    = 16'h0000;
        clear_mem();
        test_reset();
        test_mov();
        test_nop_wrap();
        test_illegal();
        test_timeout();
        test_step_halt();
        test_reset_mid_exec();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
